hiscore_ram_port: RTL and testbench

HISCORE_RAM_PORT -- requirements
Module: hiscore_ram_port

---
 rtl/hiscore_ram_port.sv | 115 +++++++++++
 tb/tb_hiscore_ram_port.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hiscore_ram_port.sv
// Arbitrates one single-port synchronous RAM between the CPU and the hiscore engine.
// Optional feature macro: HISCORE_PORT_WRITE_EN (hiscore engine may write the RAM).
module hiscore_ram_port #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ena_6,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    input  logic          cpu_we,
    output logic [7:0]    cpu_dout,
    output logic          cpu_hold,
    input  logic [AW-1:0] hs_address,
    input  logic [7:0]    hs_data_in,
    input  logic          hs_write,
    input  logic          hs_access,
    output logic [7:0]    hs_data_out,
    output logic          hs_grant,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    input  logic [7:0]    ram_dout,
    output logic [1:0]    dbg_state
);

    // Handshake: the engine raises hs_access and keeps it high; it owns the RAM
    // only while hs_grant is high, and ends ownership by dropping hs_access.
    typedef enum logic [1:0] {
        ST_CPU     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HS      = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic       guard_q, guard_d;
    logic [7:0] hs_data_q, hs_data_d;
    logic       we_raw;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_CPU;
            guard_q   <= 1'b0;
            hs_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            guard_q   <= guard_d;
            hs_data_q <= hs_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        guard_d   = guard_q;
        hs_data_d = hs_data_q;
        ram_addr  = cpu_addr;
        ram_din   = cpu_din;
        we_raw    = 1'b0;
        cpu_hold  = 1'b1;
        hs_grant  = 1'b0;
        case (state_q)
            ST_CPU: begin
                cpu_hold = 1'b0;
                we_raw   = cpu_we & ena_6;
                if (ena_6) begin
                    guard_d = 1'b0;
                end
                // After a release the CPU must complete one ena_6 cycle first.
                if (hs_access && (!guard_q || ena_6)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                we_raw = cpu_we & ena_6;
                if (!hs_access) begin
                    state_d = ST_RELEASE;
                end else if (ena_6) begin
                    state_d = ST_HS;
                end
            end
            ST_HS: begin
                ram_addr  = hs_address;
                hs_grant  = 1'b1;
                hs_data_d = ram_dout;
`ifdef HISCORE_PORT_WRITE_EN
                ram_din = hs_data_in;
                we_raw  = hs_write;
`endif
                if (!hs_access) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_CPU;
                guard_d = 1'b1;
            end
            default: begin
                state_d = ST_CPU;
            end
        endcase
    end

`ifndef HISCORE_PORT_WRITE_EN
    logic unused_hs_wr;
    assign unused_hs_wr = ^{hs_write, hs_data_in};
`endif

    // Reset kills any write in the same cycle, including one from the engine.
    assign ram_we      = we_raw & reset_n;
    assign cpu_dout    = ram_dout;
    assign hs_data_out = hs_data_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_hiscore_ram_port.sv
// Directed bench for hiscore_ram_port with a behavioural read-first RAM and a read-data scoreboard.
module tb_hiscore_ram_port;

    localparam int AW = 12;
`ifdef HISCORE_PORT_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif
    localparam logic [31:0] S_CPU = 0, S_DRAIN = 1, S_HS = 2, S_REL = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ena_6;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_we;
    logic [7:0]    cpu_dout;
    logic          cpu_hold;
    logic [AW-1:0] hs_address;
    logic [7:0]    hs_data_in;
    logic          hs_write;
    logic          hs_access;
    logic [7:0]    hs_data_out;
    logic          hs_grant;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic [7:0]    ram_dout;
    logic [1:0]    dbg_state;

    logic [7:0] mem [0:(1<<AW)-1];
    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] new_val;

    always #20 clk = ~clk;

    hiscore_ram_port #(.AW(AW)) dut (
        .clk(clk), .reset_n(reset_n), .ena_6(ena_6),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
        .cpu_hold(cpu_hold), .hs_address(hs_address), .hs_data_in(hs_data_in),
        .hs_write(hs_write), .hs_access(hs_access), .hs_data_out(hs_data_out),
        .hs_grant(hs_grant), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout), .dbg_state(dbg_state)
    );

    // Single-port synchronous RAM, read-first, one cycle read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [7:0] obs);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
        end else begin
            check(tag, {24'h0, obs}, {24'h0, exp_q.pop_front()});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'h00;
        mem[12'h3F0] <= 8'hA7;
        mem[12'h3F1] <= 8'h11;
    end

    initial begin
        new_val = WR_EN ? 8'h33 : 8'h11;
        reset_n = 1'b0; ena_6 = 1'b1; cpu_we = 1'b1; cpu_addr = '0; cpu_din = 8'h00;
        hs_address = '0; hs_data_in = 8'h00; hs_write = 1'b0; hs_access = 1'b0;
        tick(); tick();
        #1;
        check("rst_state", dbg_state, S_CPU);
        check("rst_hold", cpu_hold, 0);
        check("rst_grant", hs_grant, 0);
        check("rst_hs_data", hs_data_out, 0);
        check("rst_ram_we", ram_we, 0);
        reset_n = 1'b1; ena_6 = 1'b0; cpu_we = 1'b0;
        tick();

        // CPU write 5A at 0x010
        cpu_addr = 12'h010; cpu_din = 8'h5A; cpu_we = 1'b1; ena_6 = 1'b1;
        #1;
        check("cpu_wr_we", ram_we, 1);
        check("cpu_wr_addr", ram_addr, 12'h010);
        check("cpu_wr_din", ram_din, 8'h5A);
        check("cpu_wr_hold", cpu_hold, 0);
        check("cpu_wr_grant", hs_grant, 0);
        tick();
        ena_6 = 1'b0;
        #1;
        check("cpu_wr_once", ram_we, 0);
        check("cpu_wr_mem", mem[12'h010], 8'h5A);
        cpu_we = 1'b0;
        exp_q.push_back(8'h5A);
        tick();
        pop_check("cpu_rd_010", cpu_dout);

        // request one cycle after an ena_6 pulse
        ena_6 = 1'b1;
        tick();
        ena_6 = 1'b0; hs_access = 1'b1;
        #1;
        check("req_state", dbg_state, S_CPU);
        check("req_hold", cpu_hold, 0);
        tick();
        check("drain_state", dbg_state, S_DRAIN);
        check("drain_hold", cpu_hold, 1);
        check("drain_grant", hs_grant, 0);
        tick();
        check("drain_wait", dbg_state, S_DRAIN);
        check("drain_wait_grant", hs_grant, 0);
        ena_6 = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h020; cpu_din = 8'h77;
        #1;
        check("drain_cpu_we", ram_we, 1);
        check("drain_cpu_addr", ram_addr, 12'h020);
        check("drain_pulse_grant", hs_grant, 0);
        tick();
        check("hs_state", dbg_state, S_HS);
        check("hs_grant", hs_grant, 1);
        check("hs_hold", cpu_hold, 1);
        check("drain_mem", mem[12'h020], 8'h77);

        // HS reads, CPU write suppressed, hiscore write
        cpu_addr = 12'h030; cpu_din = 8'h99; hs_address = 12'h3F0;
        #1;
        check("hs_cpu_we_blocked", ram_we, 0);
        check("hs_addr", ram_addr, 12'h3F0);
        exp_q.push_back(8'hA7);
        tick();
        ena_6 = 1'b0; cpu_we = 1'b0;
        hs_address = 12'h3F1; hs_write = 1'b1; hs_data_in = 8'h33;
        #1;
        check("hs_wr_we", ram_we, WR_EN);
        check("hs_cpu_mem", mem[12'h030], 8'h00);
        exp_q.push_back(8'h11);
        tick();
        hs_write = 1'b0;
        pop_check("hs_rd_3f0", hs_data_out);
        check("hs_wr_mem", mem[12'h3F1], new_val);
        exp_q.push_back(new_val);
        tick();
        pop_check("hs_rd_3f1_old", hs_data_out);
        hs_access = 1'b0;
        tick();
        pop_check("hs_rd_3f1_new", hs_data_out);
        cpu_we = 1'b1; ena_6 = 1'b1; hs_write = 1'b1; cpu_addr = 12'h040; cpu_din = 8'hEE;
        #1;
        check("rel_state", dbg_state, S_REL);
        check("rel_hold", cpu_hold, 1);
        check("rel_grant", hs_grant, 0);
        check("rel_ram_we", ram_we, 0);
        tick();
        cpu_we = 1'b0; ena_6 = 1'b0; hs_write = 1'b0;
        check("rel_to_cpu", dbg_state, S_CPU);
        check("rel_cpu_hold", cpu_hold, 0);
        check("hs_data_hold", hs_data_out, new_val);
        check("rel_mem", mem[12'h040], 8'h00);
        cpu_addr = 12'h3F1;
        exp_q.push_back(new_val);
        tick();
        pop_check("cpu_rd_3f1", cpu_dout);

        // re-request right after a release must wait for a CPU ena_6
        hs_access = 1'b1;
        tick();
        check("guard_hold1", dbg_state, S_CPU);
        check("guard_cpu_hold", cpu_hold, 0);
        tick();
        check("guard_hold2", dbg_state, S_CPU);
        ena_6 = 1'b1;
        tick();
        check("guard_drain", dbg_state, S_DRAIN);
        tick();
        check("guard_hs", dbg_state, S_HS);
        ena_6 = 1'b0; hs_access = 1'b0;
        tick();
        check("guard_rel", dbg_state, S_REL);
        hs_access = 1'b1;
        tick();
        check("rel_reassert_cpu", dbg_state, S_CPU);
        tick();
        check("no_starve", dbg_state, S_CPU);
        check("no_starve_hold", cpu_hold, 0);
        ena_6 = 1'b1;
        tick();
        check("starve_drain", dbg_state, S_DRAIN);
        ena_6 = 1'b0; hs_access = 1'b0;
        tick();
        check("drain_abort_rel", dbg_state, S_REL);
        check("drain_abort_grant", hs_grant, 0);
        tick();
        check("drain_abort_cpu", dbg_state, S_CPU);

        // one-cycle request pulse: DRAIN -> RELEASE -> CPU without grant
        ena_6 = 1'b1;
        tick();
        ena_6 = 1'b0; hs_access = 1'b1;
        tick();
        check("pulse_drain", dbg_state, S_DRAIN);
        check("pulse_grant0", hs_grant, 0);
        hs_access = 1'b0;
        tick();
        check("pulse_rel", dbg_state, S_REL);
        check("pulse_grant1", hs_grant, 0);
        tick();
        check("pulse_cpu", dbg_state, S_CPU);
        check("pulse_grant2", hs_grant, 0);

        // write on HS entry cycle, then reset mid-burst
        ena_6 = 1'b1;
        tick();
        ena_6 = 1'b0; hs_access = 1'b1;
        tick();
        ena_6 = 1'b1;
        tick();
        ena_6 = 1'b0; hs_address = 12'h100; hs_data_in = 8'h44; hs_write = 1'b1;
        #1;
        check("entry_state", dbg_state, S_HS);
        check("entry_we", ram_we, WR_EN);
        tick();
        check("entry_mem", mem[12'h100], WR_EN ? 8'h44 : 8'h00);
        hs_address = 12'h101; hs_data_in = 8'h55; reset_n = 1'b0;
        #1;
        check("rst_cycle_we", ram_we, 0);
        tick();
        check("rst_hs_state", dbg_state, S_CPU);
        check("rst_hs_hold", cpu_hold, 0);
        check("rst_hs_grant", hs_grant, 0);
        check("rst_hs_data2", hs_data_out, 0);
        check("rst_hs_we", ram_we, 0);
        reset_n = 1'b1;
        #1;
        check("post_rst_we", ram_we, 0);
        hs_access = 1'b0; hs_write = 1'b0;
        tick();
        check("post_rst_state", dbg_state, S_CPU);
        check("rst_mem", mem[12'h101], 8'h00);
        check("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
